ap_unsi_wall_pipe_mult: RTL and testbench
=========================================

// Module: ap_unsi_wall_pipe_mult
// PURPOSE
//   Parametrised, 2-stage pipelined unsigned Wallace-tree multiplier.
//   - Stage 1: generates WIDTH*WIDTH partial products and reduces them to two rows with full adders / 4:2 compressors.
//   - Stage 2: final carry-propagate add.
//   - The lowest APX_COLS columns can use approximate OR-compression; this is selected per transaction at run time.
//   - Generalises the fixed 4x4 approximate compressor; used as the datapath core of the approximate-multiplier sweeps.
// PARAMETERS
//   WIDTH     8   operand width in bits (2..16)
//   APX_COLS  2   number of LSB columns (0..2*WIDTH-1) replaced by OR-compression when apx_en=1
// PORTS
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         operand beat valid
//   in_ready   out  1         stage 1 can accept a beat
//   a          in   WIDTH     multiplicand, unsigned
//   b          in   WIDTH     multiplier, unsigned
//   apx_en     in   1         1 = approximate LSB columns for this beat; 0 = exact
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer accepts result
//   res        out  2*WIDTH   product
//   apx_cnt    out  16        approx-result counter (only with AP_MULT_STAT_EN)
// BEHAVIOUR
//   - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, res=0, apx_cnt=0. in_ready=1 after reset.
//     Stage data regs clear to 0. Reset mid-operation discards all in-flight beats; no partial output.
//   - Advance rules:
//       s2_adv   = !s2_valid | out_ready
//       s1_adv   = !s1_valid | s2_adv
//       in_ready = s1_adv (combinational from out_ready; no skid buffer)
//   - Beat transfer: in accepted when in_valid & in_ready; out consumed when out_valid & out_ready.
//   - Stage 1 reg loads two reduced rows {sum_row, carry_row<<1} plus apx_en when in_valid & in_ready.
//     s1_valid <= in_valid when s1_adv; stage holds when !s1_adv.
//   - Stage 2 reg loads res = sum_row + carry_row (mod 2^(2*WIDTH)) when s2_adv & s1_valid.
//     out_valid <= s1_valid when s2_adv.
//   - Latency: 2 cycles from accept to out_valid with no back-pressure. Throughput 1 beat/cycle.
//   - Stall: out_valid=1 & out_ready=0 freezes res and out_valid. in_ready stays high only while a stage bubble exists.
//   - Simultaneous accept and consume: both complete in the same cycle; no bubble is inserted.
//   - res, out_valid and in_ready never contain X after reset, even if a and b are X while in_valid=0.
//   - Approximate column rule (column c < APX_COLS, apx_en=1):
//       result bit c = OR of all pp bits a[i]&b[j] with i+j=c.
//       No carry out of column c into c+1, and no carries into column c.
//       Column APX_COLS receives no carry from column APX_COLS-1.
//       Columns >= APX_COLS are always exact.
//   - apx_en=0, or APX_COLS=0: res == a*b exactly.
//   - Error bound: approx res <= exact res, always.
//   - Width: partial products are zero-extended to 2*WIDTH bits. res never wraps for exact mode.
// CONFIGURATION
//   AP_MULT_STAT_EN defined:
//     - Adds port apx_cnt[15:0].
//     - apx_cnt increments on every consumed beat (out_valid & out_ready) that had apx_en=1.
//     - apx_cnt saturates at 16'hFFFF and is cleared only by rst_n.
//   AP_MULT_STAT_EN undefined:
//     - No apx_cnt port and no counter logic.
//     - apx_en is still carried through the pipeline; datapath behaviour is identical.
// STRUCTURE
//   - Package ap_mult_pkg holds:
//       - localparam function col_height(c, W) = number of pp bits in column c.
//       - typedef for the reduced-row pair struct {sum_row, carry_row}.
//       - reset constants.
//   - Sub-module ap_col_or_cmp (N-input OR column compressor, parameter N):
//       - instantiated for each column c < APX_COLS.
//       - output muxed against the exact tree result by the stage-1 apx_en.
//   - Exact reduction tree: generate loop of the existing fa / com cells, reducing by column until height <= 2.
// TESTING
//   - Run all scenarios at WIDTH=8, APX_COLS=2.
//   1) Reset, then a=3, b=3, apx_en=1: out_valid 2 cycles later, res=7. Same operands with apx_en=0: res=9.
//   2) a=255, b=255: apx_en=0 gives res=65025; apx_en=1 gives res=65023.
//   3) Back-to-back 100 random beats, out_ready=1: one result per cycle, in order.
//      res matches the golden model (exact or OR-column model per beat).
//   4) out_ready=0 for 5 cycles with 3 beats offered:
//      - exactly 2 beats accepted; in_ready=0 afterwards.
//      - res stable during the stall.
//      - on release, results drain in order with no loss or duplication.
//   5) Assert rst_n=0 with 2 beats in flight: out_valid=0 and res=0 immediately (async).
//      After release, no stale result appears.
//   6) With AP_MULT_STAT_EN: 3 apx beats and 2 exact beats consumed gives apx_cnt=3.
//      Force the count to 16'hFFFF, consume one more apx beat: apx_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/ap_mult_pkg.sv
// ============================================================================
// Module   : ap_mult_pkg
// Brief    : Shared types, reset constants and column/tree sizing helpers for
//            the approximate Wallace-tree multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ap_mult_pkg;

  localparam int c_max_width = 16;
  localparam int c_max_pw    = 2 * c_max_width;

  typedef struct packed {
    logic [c_max_pw-1:0] sum_row;
    logic [c_max_pw-1:0] carry_row;
  } red_rows_t;

  localparam red_rows_t   c_rst_rows  = '0;
  localparam logic        c_rst_valid = 1'b0;
  localparam logic [15:0] c_rst_cnt   = 16'h0000;

  // Number of partial-product bits a[i]&b[j] with i+j == c.
  function automatic int col_height(input int c, input int w);
    if (c < w)             return c + 1;
    else if (c < 2*w - 1)  return 2*w - 1 - c;
    else                   return 0;
  endfunction

  // Lowest multiplicand index contributing to column c.
  function automatic int col_lo(input int c, input int w);
    return (c < w) ? 0 : c - w + 1;
  endfunction

  function automatic int rows_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int lvl, input int w);
    int n;
    n = w;
    for (int l = 0; l < lvl; l++) n = rows_next(n);
    return n;
  endfunction

  function automatic int csa_levels(input int w);
    int n;
    int l;
    n = w;
    l = 0;
    while (n > 2) begin
      n = rows_next(n);
      l++;
    end
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ap_col_or_cmp.sv
// ============================================================================
// Module   : ap_col_or_cmp
// Brief    : N-input OR compressor collapsing one partial-product column.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ap_col_or_cmp #(
  parameter int N = 2
) (
  input  logic [N-1:0] bits,
  output logic         y
);

  assign y = |bits;

endmodule

`default_nettype wire

// File: rtl/ap_unsi_wall_pipe_mult.sv
// ============================================================================
// Module   : ap_unsi_wall_pipe_mult
// Brief    : 2-stage pipelined unsigned Wallace-tree multiplier with run-time
//            OR-approximated LSB columns. AP_MULT_STAT_EN adds apx_cnt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ap_unsi_wall_pipe_mult
  import ap_mult_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int APX_COLS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               apx_en,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef AP_MULT_STAT_EN
  output logic [15:0]        apx_cnt,
`endif
  output logic [2*WIDTH-1:0] res
);

  localparam int c_pw   = 2 * WIDTH;
  localparam int c_lvls = csa_levels(WIDTH);
  localparam logic [c_pw-1:0] c_low_mask = (c_pw'(1) << APX_COLS) - c_pw'(1);

  logic              r_s1_valid;
  red_rows_t         r_s1_rows;
  logic              r_s1_apx;
  logic              r_s2_valid;
  logic [c_pw-1:0]   r_res;
  logic              r_s2_apx;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic [c_pw-1:0]   w_pp_mask;
  logic [c_pw-1:0]   w_lvl [c_lvls+1][WIDTH];
  logic [c_pw-1:0]   w_tree_sum;
  logic [c_pw-1:0]   w_tree_carry;
  red_rows_t         w_rows;
  logic [c_max_pw-1:0] w_full;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign res       = r_res;

  // Approximate beats drop the low columns from the tree so no carry leaves them.
  assign w_pp_mask = apx_en ? ~c_low_mask : '1;

  for (genvar r = 0; r < WIDTH; r++) begin : g_pp
    assign w_lvl[0][r] = (c_pw'(a & {WIDTH{b[r]}}) << r) & w_pp_mask;
  end

  for (genvar l = 0; l < c_lvls; l++) begin : g_lvl
    localparam int c_n   = rows_at(l, WIDTH);
    localparam int c_grp = c_n / 3;
    localparam int c_rem = c_n % 3;
    localparam int c_nn  = rows_next(c_n);
    for (genvar g = 0; g < c_grp; g++) begin : g_csa
      assign w_lvl[l+1][2*g]   = w_lvl[l][3*g] ^ w_lvl[l][3*g+1] ^ w_lvl[l][3*g+2];
      assign w_lvl[l+1][2*g+1] = ((w_lvl[l][3*g]   & w_lvl[l][3*g+1]) |
                                  (w_lvl[l][3*g]   & w_lvl[l][3*g+2]) |
                                  (w_lvl[l][3*g+1] & w_lvl[l][3*g+2])) << 1;
    end
    for (genvar r = 0; r < c_rem; r++) begin : g_pass
      assign w_lvl[l+1][2*c_grp+r] = w_lvl[l][3*c_grp+r];
    end
    for (genvar r = c_nn; r < WIDTH; r++) begin : g_fill
      assign w_lvl[l+1][r] = '0;
    end
  end

  assign w_tree_sum   = w_lvl[c_lvls][0];
  assign w_tree_carry = w_lvl[c_lvls][1];

  if (APX_COLS > 0) begin : g_apx
    logic [APX_COLS-1:0] w_or;
    for (genvar c = 0; c < APX_COLS; c++) begin : g_col
      localparam int c_h  = col_height(c, WIDTH);
      localparam int c_lo = col_lo(c, WIDTH);
      logic [c_h-1:0] w_bits;
      for (genvar k = 0; k < c_h; k++) begin : g_bit
        assign w_bits[k] = a[c_lo+k] & b[c-c_lo-k];
      end
      ap_col_or_cmp #(.N(c_h)) u_or (
        .bits (w_bits),
        .y    (w_or[c])
      );
    end
    always_comb begin
      w_rows = c_rst_rows;
      w_rows.sum_row[c_pw-1:0]   = w_tree_sum;
      w_rows.carry_row[c_pw-1:0] = w_tree_carry;
      if (apx_en) w_rows.sum_row[APX_COLS-1:0] = w_or;
    end
  end else begin : g_exact
    always_comb begin
      w_rows = c_rst_rows;
      w_rows.sum_row[c_pw-1:0]   = w_tree_sum;
      w_rows.carry_row[c_pw-1:0] = w_tree_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= c_rst_valid;
      r_s1_rows  <= c_rst_rows;
      r_s1_apx   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_rows <= w_rows;
        r_s1_apx  <= apx_en;
      end
    end
  end

  assign w_full = r_s1_rows.sum_row + r_s1_rows.carry_row;

  if (c_pw < c_max_pw) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = |w_full[c_max_pw-1:c_pw];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= c_rst_valid;
      r_res      <= '0;
      r_s2_apx   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res    <= w_full[c_pw-1:0];
        r_s2_apx <= r_s1_apx;
      end
    end
  end

`ifdef AP_MULT_STAT_EN
  logic [15:0] r_apx_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_apx_cnt <= c_rst_cnt;
    end else if (r_s2_valid && out_ready && r_s2_apx && (r_apx_cnt != 16'hFFFF)) begin
      r_apx_cnt <= r_apx_cnt + 16'd1;
    end
  end

  assign apx_cnt = r_apx_cnt;
`else
  logic w_unused_apx;
  assign w_unused_apx = r_s2_apx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ap_unsi_wall_pipe_mult.sv
// ============================================================================
// Module   : tb_ap_unsi_wall_pipe_mult
// Brief    : Self-checking bench for ap_unsi_wall_pipe_mult (WIDTH=8, APX_COLS=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ap_unsi_wall_pipe_mult;

  localparam int W = 8;
  localparam int K = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           apx_en = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] res;
`ifdef AP_MULT_STAT_EN
  logic [15:0]    apx_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic [2*W-1:0] sb [$];

  always #5 clk = ~clk;

  ap_unsi_wall_pipe_mult #(.WIDTH(W), .APX_COLS(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .apx_en    (apx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AP_MULT_STAT_EN
    .apx_cnt   (apx_cnt),
`endif
    .res       (res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact columns sum arithmetically; approximated low columns just OR their bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ap);
    logic [31:0]    acc;
    logic [2*W-1:0] lo;
    acc = 32'd0;
    lo  = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && y[j]) begin
          if (ap && (i + j) < K) lo[i+j] = 1'b1;
          else                   acc = acc + (32'd1 << (i + j));
        end
    return acc[2*W-1:0] | lo;
  endfunction

  // Called at a falling edge with inputs already set; advances one cycle.
  task automatic step();
    logic [2*W-1:0] e;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("res", res, e);
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(a, b, apx_en));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic single(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ap, input logic [2*W-1:0] exp);
    a = x; b = y; apx_en = ap; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("single_in_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat1_valid", out_valid, 0);
    @(posedge clk); @(negedge clk);
    #1 chk("lat2_valid", out_valid, 1);
    chk(tag, res, exp);
    @(posedge clk); @(negedge clk);
  endtask

  logic [W-1:0]   xa [3];
  logic [W-1:0]   xb [3];
  logic           xp [3];
  logic [2*W-1:0] held;
  int             base;

  initial begin
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    single("res_3x3_apx", 8'd3, 8'd3, 1'b1, 16'd7);
    single("res_3x3_exact", 8'd3, 8'd3, 1'b0, 16'd9);
    single("res_255_exact", 8'd255, 8'd255, 1'b0, 16'd65025);
    single("res_255_apx", 8'd255, 8'd255, 1'b1, 16'd65023);

    // Back-to-back random stream.
    n_acc = 0; n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom); b = W'($urandom); apx_en = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      step();
    end
    chk("stream_acc", n_acc, 100);
    chk("stream_out_inflight", n_out, 98);
    drain(10);
    chk("stream_out", n_out, 100);

    // Stall with three beats offered.
    for (int i = 0; i < 3; i++) begin
      xa[i] = W'($urandom); xb[i] = W'($urandom); xp[i] = 1'($urandom_range(0, 1));
    end
    n_acc = 0; base = n_out; held = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (n_acc < 3) begin
        a = xa[n_acc]; b = xb[n_acc]; apx_en = xp[n_acc];
      end
      in_valid = (n_acc < 3);
      step();
      if (i == 2) held = res;
    end
    chk("stall_acc", n_acc, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_res_hold", res, held);
    chk("stall_no_out", n_out - base, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (n_acc >= 3) break;
      a = xa[n_acc]; b = xb[n_acc]; apx_en = xp[n_acc];
      in_valid = 1'b1;
      step();
    end
    chk("stall_all_acc", n_acc, 3);
    drain(10);
    chk("stall_drain_cnt", n_out - base, 3);

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = W'($urandom) | 8'h01; b = W'($urandom) | 8'h01; apx_en = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_res", res, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", out_valid, 0);
    end

`ifdef AP_MULT_STAT_EN
    chk("cnt_rst", apx_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); apx_en = (i % 2 == 0);
      in_valid = 1'b1;
      step();
    end
    drain(10);
    chk("cnt_three", apx_cnt, 3);
    for (int i = 0; i < 65532; i++) begin
      a = W'($urandom); b = W'($urandom); apx_en = 1'b1;
      in_valid = 1'b1;
      step();
    end
    drain(10);
    chk("cnt_full", apx_cnt, 32'h0000FFFF);
    a = 8'd5; b = 8'd7; apx_en = 1'b1; in_valid = 1'b1;
    step();
    drain(10);
    chk("cnt_sat", apx_cnt, 32'h0000FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
